hazard_forward_ctrl: RTL and testbench
======================================

Name: hazard_forward_ctrl

Overview:
- Parametrised forwarding and hazard controller for the pipelined MIPS CPU; successor to the two-operand EX-stage forwarding logic.
- Generalised to NUM_SRC operands and NUM_FWD forwarding stages; each operand resolves independently with youngest-stage priority.
- Adds a load-use stall FSM with configurable LOAD_LAT, a data-memory busy freeze, and saturating performance counters.

Parameters:
REG_AW, 5, register address width
NUM_SRC, 2, source operands per instruction (rs, rt, ...)
NUM_FWD, 2, forwarding stages; index 0 = EX/MEM (youngest), 1 = MEM/WB, ...
LOAD_LAT, 1, load-use stall cycles (>=1)
EXCL_LINK, 1, when 1 the link register (31) never forwards
CNT_W, 32, statistics counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
id_src_addr  in  NUM_SRC*REG_AW  ID-stage source registers (operand i at slice i)
id_src_used  in  NUM_SRC  ID operand i actually read
ex_src_addr  in  NUM_SRC*REG_AW  ID/EX source registers
ex_is_load  in  1  ID/EX holds a load
ex_wr_en  in  1  ID/EX writes a register
ex_rd  in  REG_AW  ID/EX destination
fwd_wr_en  in  NUM_FWD  stage k writes a register
fwd_rd  in  NUM_FWD*REG_AW  stage k destination
mem_busy  in  1  data memory not ready
clr_stats  in  1  synchronous counter clear
fwd_sel  out  NUM_SRC*SELW  per operand: 0 = register file, k+1 = stage k; SELW = clog2(NUM_FWD+1)
stall_if  out  1  hold PC
stall_id  out  1  hold IF/ID
stall_ex  out  1  hold ID/EX and later stages (freeze)
bubble_ex  out  1  load NOP into ID/EX
stall_cycles  out  CNT_W  cycles with stall_id=1
fwd_events  out  CNT_W  cycles with any fwd_sel != 0

Behaviour:
- Forwarding is combinational, zero latency. Stage k matches operand i when fwd_wr_en[k], fwd_rd[k] != 0, (!EXCL_LINK or fwd_rd[k] != 31), and fwd_rd[k] == ex_src_addr[i]. The lowest matching k wins: fwd_sel[i] = k+1. No match gives 0. Operands are fully independent, so both may forward in the same cycle, from the same stage or from different stages.
- Load-use detect (hz): ex_is_load & ex_wr_en & ex_rd != 0 & exists i with id_src_used[i] & id_src_addr[i] == ex_rd.
- FSM states: IDLE and STALL, with down-counter cnt (width clog2(LOAD_LAT+1)).
  - IDLE, !mem_busy, hz: stall_if = stall_id = bubble_ex = 1 this cycle. If LOAD_LAT > 1, go to STALL with cnt = LOAD_LAT-1; otherwise stay in IDLE.
  - STALL, !mem_busy: stall_if = stall_id = bubble_ex = 1; cnt decrements. When cnt == 1, go to IDLE. hz is ignored in STALL.
  - Total load-use stall is exactly LOAD_LAT cycles.
- mem_busy = 1 (priority over everything):
  - stall_if = stall_id = stall_ex = 1, bubble_ex = 0.
  - FSM state and cnt hold.
  - hz is not acted on; it is re-evaluated after release.
- stall_ex is asserted only by mem_busy.
- Counters:
  - stall_cycles increments when stall_id = 1; fwd_events increments when any operand forwards.
  - Both saturate at all-ones.
  - clr_stats has priority over increment: the counter reads 0 next cycle, and that cycle's event is dropped.
- Reset:
  - While rst = 1, all stall/bubble outputs are 0 and fwd_sel is 0.
  - Next state is IDLE, cnt = 0, counters = 0.
  - Reset during STALL abandons the stall immediately.

Decomposition:
- Package cpu_hazard_pkg holds:
  - state enum {HZ_IDLE, HZ_STALL}
  - SEL_REGFILE = 0, ZERO_REG = 0, LINK_REG = 31
- Sub-module fwd_src_select: a combinational priority encoder for one operand, instantiated NUM_SRC times via generate.

Test Plan:
1. Defaults; fwd_wr_en = 2'b11, fwd_rd = {MEMWB=8, EXMEM=8}, ex_src = {rt=9, rs=8} -> fwd_sel rs = 1 (EX/MEM wins), rt = 0.
2. fwd_rd = {MEMWB=9, EXMEM=8}, ex_src = {rt=9, rs=8}, both write -> rs = 1 and rt = 2 in the same cycle. Repeat with rd = 0 and rd = 31 -> 0.
3. ex_is_load = 1, ex_rd = 4, id_src_addr rs = 4, used = 1 -> one cycle of stall_if/stall_id/bubble_ex; stall_cycles = 1. With id_src_used = 0 -> no stall.
4. LOAD_LAT = 3, same load-use -> exactly 3 stall cycles. Hold mem_busy on the 2nd -> stall_ex = 1, bubble_ex = 0, cnt frozen, 3 bubble cycles still delivered.
5. Assert rst in the middle of a LOAD_LAT = 3 stall -> outputs 0 during reset, IDLE after, counters 0.
6. Force stall_cycles = all-ones minus 1, hold stall 3 cycles -> saturates at all-ones. clr_stats together with an event -> 0.

Source files
------------

// File: rtl/cpu_hazard_pkg.sv
// rtl/cpu_hazard_pkg.sv - shared types and constants for the hazard/forwarding controller
package cpu_hazard_pkg;

    typedef enum logic {
        HZ_IDLE,
        HZ_STALL
    } hzState_t;

    localparam int SEL_REGFILE = 0;
    localparam int ZERO_REG    = 0;
    localparam int LINK_REG    = 31;

endpackage

// File: rtl/fwd_src_select.sv
// rtl/fwd_src_select.sv - priority forwarding source select for one operand
module fwd_src_select
    import cpu_hazard_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int NUM_FWD   = 2,
    parameter int EXCL_LINK = 1,
    parameter int SELW      = 2
) (
    input  logic [REG_AW-1:0]         srcAddr,
    input  logic [NUM_FWD-1:0]        fwdWrEn,
    input  logic [NUM_FWD*REG_AW-1:0] fwdRd,
    output logic [SELW-1:0]           sel
);

    logic [REG_AW-1:0] rd;

    // Walk oldest to youngest so the youngest matching stage is written last.
    always_comb begin
        sel = SELW'(SEL_REGFILE);
        rd  = '0;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            rd = fwdRd[k*REG_AW +: REG_AW];
            if (fwdWrEn[k] && (rd != REG_AW'(ZERO_REG)) &&
                ((EXCL_LINK == 0) || (rd != REG_AW'(LINK_REG))) &&
                (rd == srcAddr)) begin
                sel = SELW'(k + 1);
            end
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// rtl/hazard_forward_ctrl.sv - operand forwarding, load-use stall FSM, memory freeze and stats
module hazard_forward_ctrl
    import cpu_hazard_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int NUM_SRC   = 2,
    parameter int NUM_FWD   = 2,
    parameter int LOAD_LAT  = 1,
    parameter int EXCL_LINK = 1,
    parameter int CNT_W     = 32,
    localparam int SELW     = $clog2(NUM_FWD + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic [NUM_SRC*REG_AW-1:0] ex_src_addr,
    input  logic                      ex_is_load,
    input  logic                      ex_wr_en,
    input  logic [REG_AW-1:0]         ex_rd,
    input  logic [NUM_FWD-1:0]        fwd_wr_en,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_rd,
    input  logic                      mem_busy,
    input  logic                      clr_stats,
    output logic [NUM_SRC*SELW-1:0]   fwd_sel,
    output logic                      stall_if,
    output logic                      stall_id,
    output logic                      stall_ex,
    output logic                      bubble_ex,
    output logic [CNT_W-1:0]          stall_cycles,
    output logic [CNT_W-1:0]          fwd_events
);

    localparam int CNTW = $clog2(LOAD_LAT + 1);

    hzState_t            state;
    logic [CNTW-1:0]     cnt;
    logic [NUM_SRC*SELW-1:0] selRaw;
    logic                hz;
    logic                loadStall;

    for (genvar i = 0; i < NUM_SRC; i++) begin : gSrc
        fwd_src_select #(
            .REG_AW   (REG_AW),
            .NUM_FWD  (NUM_FWD),
            .EXCL_LINK(EXCL_LINK),
            .SELW     (SELW)
        ) uSel (
            .srcAddr(ex_src_addr[i*REG_AW +: REG_AW]),
            .fwdWrEn(fwd_wr_en),
            .fwdRd  (fwd_rd),
            .sel    (selRaw[i*SELW +: SELW])
        );
    end

    always_comb begin
        hz = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_src_used[i] && (id_src_addr[i*REG_AW +: REG_AW] == ex_rd)) begin
                hz = 1'b1;
            end
        end
        hz = hz && ex_is_load && ex_wr_en && (ex_rd != REG_AW'(ZERO_REG));
    end

    // A busy data memory freezes everything, so the bubble is deferred, not lost.
    assign loadStall = !mem_busy && ((state == HZ_STALL) || hz);
    assign fwd_sel   = rst ? '0 : selRaw;
    assign stall_if  = !rst && (mem_busy || loadStall);
    assign stall_id  = !rst && (mem_busy || loadStall);
    assign stall_ex  = !rst && mem_busy;
    assign bubble_ex = !rst && loadStall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HZ_IDLE;
            cnt   <= '0;
        end else if (!mem_busy) begin
            case (state)
                HZ_IDLE: begin
                    if (hz && (LOAD_LAT > 1)) begin
                        state <= HZ_STALL;
                        cnt   <= CNTW'(LOAD_LAT - 1);
                    end
                end
                HZ_STALL: begin
                    if (cnt == CNTW'(1)) begin
                        state <= HZ_IDLE;
                    end
                    cnt <= cnt - CNTW'(1);
                end
                default: begin
                    state <= HZ_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            stall_cycles <= '0;
            fwd_events   <= '0;
        end else begin
            if (stall_id && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if ((fwd_sel != '0) && (fwd_events != '1)) begin
                fwd_events <= fwd_events + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb/tb_hazard_forward_ctrl.sv - self-checking bench for hazard_forward_ctrl
module tb_hazard_forward_ctrl;

    localparam int AW = 5;
    localparam longint MAXA = 64'hFFFF_FFFF;
    localparam longint MAXB = 31;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  idSrcAddr;
    logic [1:0]  idSrcUsed;
    logic [9:0]  exSrcAddr;
    logic        exIsLoad, exWrEn;
    logic [4:0]  exRd;
    logic [1:0]  fwdWrEn;
    logic [9:0]  fwdRd;
    logic        memBusy, clrStats;

    logic [3:0]  selA, selB;
    logic        sIfA, sIdA, sExA, bubA, sIfB, sIdB, sExB, bubB;
    logic [31:0] scA, feA;
    logic [4:0]  scB, feB;

    always #5 clk = ~clk;

    hazard_forward_ctrl #(.LOAD_LAT(1), .CNT_W(32)) dutA (
        .clk(clk), .rst(rst), .id_src_addr(idSrcAddr), .id_src_used(idSrcUsed),
        .ex_src_addr(exSrcAddr), .ex_is_load(exIsLoad), .ex_wr_en(exWrEn), .ex_rd(exRd),
        .fwd_wr_en(fwdWrEn), .fwd_rd(fwdRd), .mem_busy(memBusy), .clr_stats(clrStats),
        .fwd_sel(selA), .stall_if(sIfA), .stall_id(sIdA), .stall_ex(sExA), .bubble_ex(bubA),
        .stall_cycles(scA), .fwd_events(feA)
    );

    hazard_forward_ctrl #(.LOAD_LAT(3), .CNT_W(5)) dutB (
        .clk(clk), .rst(rst), .id_src_addr(idSrcAddr), .id_src_used(idSrcUsed),
        .ex_src_addr(exSrcAddr), .ex_is_load(exIsLoad), .ex_wr_en(exWrEn), .ex_rd(exRd),
        .fwd_wr_en(fwdWrEn), .fwd_rd(fwdRd), .mem_busy(memBusy), .clr_stats(clrStats),
        .fwd_sel(selB), .stall_if(sIfB), .stall_id(sIdB), .stall_ex(sExB), .bubble_ex(bubB),
        .stall_cycles(scB), .fwd_events(feB)
    );

    int nChecks = 0;
    int nFails  = 0;

    // Reference state: remaining load-use bubbles owed and counter values.
    int     remA = 0, remB = 0;
    longint mScA = 0, mScB = 0, mFeA = 0, mFeB = 0;

    logic [3:0]  lastA, lastB, lastSelA;
    logic [31:0] lastScA;
    logic [4:0]  lastScB;

    typedef struct {
        string      name;
        logic [1:0] wr;
        logic [4:0] rd0, rd1, rs, rt;
        logic [3:0] sel;
    } fvec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int refSel(input int i);
        logic [4:0] rd, src;
        src = exSrcAddr[i*AW +: AW];
        for (int k = 0; k < 2; k++) begin
            rd = fwdRd[k*AW +: AW];
            if (fwdWrEn[k] && rd != 5'd0 && rd != 5'd31 && rd == src) return k + 1;
        end
        return 0;
    endfunction

    function automatic logic refHz();
        logic hit = 1'b0;
        for (int i = 0; i < 2; i++)
            if (idSrcUsed[i] && idSrcAddr[i*AW +: AW] == exRd) hit = 1'b1;
        return hit && exIsLoad && exWrEn && exRd != 5'd0;
    endfunction

    function automatic longint satInc(input longint v, input longint mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    function automatic logic [4:0] pickReg();
        int r = $urandom_range(0, 5);
        return (r == 5) ? 5'd31 : 5'(r);
    endfunction

    task automatic quiet();
        rst = 0; idSrcAddr = '0; idSrcUsed = '0; exSrcAddr = '0; exIsLoad = 0; exWrEn = 0;
        exRd = '0; fwdWrEn = '0; fwdRd = '0; memBusy = 0; clrStats = 0;
    endtask

    // One clock: compare every output against the model at negedge, then advance the model.
    task automatic cycle();
        logic [3:0] eSel, eA, eB;
        logic hz, bA, bB;
        @(negedge clk);
        eSel = rst ? 4'd0 : 4'((refSel(1) << 2) | refSel(0));
        hz = refHz();
        bA = !rst && !memBusy && (remA > 0 || hz);
        bB = !rst && !memBusy && (remB > 0 || hz);
        eA = {!rst && (memBusy || bA), !rst && (memBusy || bA), !rst && memBusy, bA};
        eB = {!rst && (memBusy || bB), !rst && (memBusy || bB), !rst && memBusy, bB};
        lastA = {sIfA, sIdA, sExA, bubA};
        lastB = {sIfB, sIdB, sExB, bubB};
        lastSelA = selA; lastScA = scA; lastScB = scB;
        check("fwd_sel_a", selA, eSel);
        check("fwd_sel_b", selB, eSel);
        check("stall_a", lastA, eA);
        check("stall_b", lastB, eB);
        check("stall_cycles_a", scA, mScA);
        check("stall_cycles_b", scB, mScB);
        check("fwd_events_a", feA, mFeA);
        check("fwd_events_b", feB, mFeB);
        @(posedge clk);
        if (rst) begin
            remA = 0; remB = 0; mScA = 0; mScB = 0; mFeA = 0; mFeB = 0;
        end else begin
            if (clrStats) begin
                mScA = 0; mScB = 0; mFeA = 0; mFeB = 0;
            end else begin
                if (eA[2]) mScA = satInc(mScA, MAXA);
                if (eB[2]) mScB = satInc(mScB, MAXB);
                if (eSel != 0) begin
                    mFeA = satInc(mFeA, MAXA);
                    mFeB = satInc(mFeB, MAXB);
                end
            end
            if (!memBusy) begin
                if (remA > 0) remA--; else if (hz) remA = 0;
                if (remB > 0) remB--; else if (hz) remB = 2;
            end
        end
        #1;
    endtask

    task automatic loadUse(input logic [1:0] used);
        exIsLoad = 1; exWrEn = 1; exRd = 5'd4; idSrcAddr = {5'd0, 5'd4}; idSrcUsed = used;
    endtask

    fvec_t tbl[7];

    initial begin
        tbl[0] = '{"ex_mem_wins",  2'b11, 5'd8,  5'd8,  5'd8,  5'd9,  4'b0001};
        tbl[1] = '{"both_operands", 2'b11, 5'd8,  5'd9,  5'd8,  5'd9,  4'b1001};
        tbl[2] = '{"rd_zero",      2'b11, 5'd0,  5'd0,  5'd0,  5'd0,  4'b0000};
        tbl[3] = '{"rd_link",      2'b11, 5'd31, 5'd31, 5'd31, 5'd31, 4'b0000};
        tbl[4] = '{"no_write",     2'b00, 5'd8,  5'd9,  5'd8,  5'd9,  4'b0000};
        tbl[5] = '{"same_stage",   2'b01, 5'd8,  5'd8,  5'd8,  5'd8,  4'b0101};
        tbl[6] = '{"mem_wb_only",  2'b10, 5'd8,  5'd8,  5'd8,  5'd3,  4'b0010};

        quiet();
        rst = 1; loadUse(2'b01); memBusy = 1; fwdWrEn = 2'b11; fwdRd = {5'd8, 5'd8}; exSrcAddr = {5'd8, 5'd8};
        cycle();
        check("reset_outputs", {lastA, lastB, lastSelA}, 12'd0);
        memBusy = 0;
        cycle();
        quiet();
        cycle();

        foreach (tbl[n]) begin
            quiet();
            fwdWrEn = tbl[n].wr; fwdRd = {tbl[n].rd1, tbl[n].rd0}; exSrcAddr = {tbl[n].rt, tbl[n].rs};
            cycle();
            check(tbl[n].name, lastSelA, tbl[n].sel);
        end

        // Single-cycle load-use on the LOAD_LAT=1 instance.
        quiet(); clrStats = 1; cycle();
        quiet(); loadUse(2'b01); cycle();
        check("lu1_stall", lastA, 4'b1101);
        quiet(); cycle();
        check("lu1_release", lastA, 4'b0000);
        check("lu1_count", lastScA, 1);
        loadUse(2'b00); cycle();
        check("lu1_unused", lastA, 4'b0000);

        // LOAD_LAT=3 with a memory freeze on the second stall cycle.
        quiet(); repeat (3) cycle();
        clrStats = 1; cycle(); clrStats = 0;
        loadUse(2'b01); cycle();
        check("lu3_c1", lastB, 4'b1101);
        memBusy = 1; cycle();
        check("lu3_busy", lastB, 4'b1110);
        memBusy = 0; cycle();
        check("lu3_c3", lastB, 4'b1101);
        cycle();
        check("lu3_c4", lastB, 4'b1101);
        exIsLoad = 0; cycle();
        check("lu3_done", lastB, 4'b0000);
        check("lu3_count", lastScB, 4);

        // Reset in the middle of a stall.
        quiet(); loadUse(2'b01); cycle();
        rst = 1; cycle();
        check("rst_mid_stall", lastB, 4'b0000);
        cycle();
        quiet(); cycle();
        check("rst_idle_after", lastB, 4'b0000);
        check("rst_counter_b", lastScB, 0);
        check("rst_counter_a", lastScA, 0);

        // Saturation of the 5-bit counter and clear-over-event priority.
        quiet(); clrStats = 1; cycle(); clrStats = 0;
        memBusy = 1;
        repeat (31) cycle();
        check("sat_pre", lastScB, 30);
        repeat (3) cycle();
        check("sat_hold", lastScB, 31);
        clrStats = 1; cycle(); clrStats = 0; cycle();
        check("clr_priority", lastScB, 0);

        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            memBusy = ($urandom_range(0, 4) == 0);
            clrStats = ($urandom_range(0, 39) == 0);
            idSrcAddr = {pickReg(), pickReg()};
            idSrcUsed = 2'($urandom_range(0, 3));
            exSrcAddr = {pickReg(), pickReg()};
            exIsLoad = ($urandom_range(0, 2) == 0);
            exWrEn = ($urandom_range(0, 3) != 0);
            exRd = pickReg();
            fwdWrEn = 2'($urandom_range(0, 3));
            fwdRd = {pickReg(), pickReg()};
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
